// File: rtl/dotmatrix_pkg.sv
// Shared types and constants for the dot-matrix scroll sequencer.
// Holds the FSM state encoding, display geometry and a counter-width helper.
package dotmatrix_pkg;

  localparam int DISP_TICK = 2500;
  localparam int DM_ROWS   = 8;
  localparam int DM_ADDR_W = 8;
  localparam int DM_ROW_W  = $clog2(DM_ROWS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RELEASE,
    FRAME_END,
    WAIT_STEP,
    ADVANCE_OFS
  } dm_state_t;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dotmatrix_tick_gen.sv
// Base-tick prescaler: one-cycle tick every TICK_DIV cycles.
// A synchronous clear restarts the count so the next tick lands TICK_DIV cycles later.
module dotmatrix_tick_gen
  import dotmatrix_pkg::*;
#(
  parameter int TICK_DIV = DISP_TICK
) (
  input  logic mclock,
  input  logic mreset,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W    = cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge mclock) begin
    if (mreset || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST) && !clear;

endmodule

// File: rtl/dotmatrix_scroll_ctrl.sv
// Scroll sequencer: rebuilds the 8 row bytes of a scrolling column window and
// writes them to the dot-matrix peripheral with a CS/Write/ack handshake.
module dotmatrix_scroll_ctrl
  import dotmatrix_pkg::*;
#(
  parameter int TICK_DIV    = DISP_TICK,
  parameter int STEP_TICKS  = 1000,
  parameter int MSG_COLS    = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 mclock,
  input  logic                 mreset,
  input  logic                 enable,
  input  logic                 cfg_we,
  input  logic [4:0]           cfg_addr,
  input  logic [7:0]           cfg_data,
  output logic                 dm_CS,
  output logic                 dm_Write,
  output logic [DM_ADDR_W-1:0] dm_Address,
  output logic [7:0]           dm_Data,
  input  logic                 dm_ack,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 ack_err
);

  localparam int                   COL_IDX_W = cnt_width(MSG_COLS);
  localparam int                   STEP_W    = cnt_width(STEP_TICKS);
  localparam int                   TMO_W     = cnt_width(ACK_TIMEOUT);
  localparam logic [5:0]           COLS_SUM  = 6'(MSG_COLS);
  localparam logic [4:0]           LAST_COL  = 5'(MSG_COLS - 1);
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [DM_ROW_W-1:0]  ROW_LAST  = DM_ROW_W'(DM_ROWS - 1);

  dm_state_t            state, state_nxt;
  logic [DM_ROW_W-1:0]  row, row_nxt;
  logic [4:0]           ofs, ofs_nxt;
  logic [STEP_W-1:0]    step;
  logic [TMO_W-1:0]     tmo;
  logic                 tick;
  logic                 pre_clr;
  logic                 set_err;
  logic                 load_row;
  logic [7:0]           row_byte;
  logic [7:0]           msg [MSG_COLS];

  // Window column c maps to message column (base + c) mod MSG_COLS; both
  // operands are below MSG_COLS and MSG_COLS >= 8, so one subtract suffices.
  function automatic logic [COL_IDX_W-1:0] wrap_col(input logic [4:0] base, input int c);
    logic [5:0] s;
    s = {1'b0, base} + 6'(c);
    if (s >= COLS_SUM) s = s - COLS_SUM;
    return s[COL_IDX_W-1:0];
  endfunction

  dotmatrix_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .mclock (mclock),
    .mreset (mreset),
    .clear  (pre_clr),
    .tick   (tick)
  );

  always_ff @(posedge mclock) begin
    if (cfg_we && ({1'b0, cfg_addr} < COLS_SUM)) begin
      msg[cfg_addr[COL_IDX_W-1:0]] <= cfg_data;
    end
  end

  always_comb begin
    row_byte = '0;
    for (int c = 0; c < 8; c++) begin
      row_byte[c] = msg[wrap_col(ofs_nxt, c)][row_nxt];
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    ofs_nxt   = ofs;
    set_err   = 1'b0;
    pre_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = WRITE;
          row_nxt   = '0;
        end
      end
      WRITE: begin
        if (dm_ack) begin
          state_nxt = RELEASE;
        end else if (tmo == TMO_LAST) begin
          set_err   = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (row != ROW_LAST) begin
          row_nxt   = row + 1'b1;
          state_nxt = WRITE;
        end else begin
          state_nxt = FRAME_END;
        end
      end
      FRAME_END: begin
        pre_clr   = 1'b1;
        state_nxt = WAIT_STEP;
      end
      WAIT_STEP: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (tick && (step == STEP_LAST)) begin
          state_nxt = ADVANCE_OFS;
        end
      end
      ADVANCE_OFS: begin
        ofs_nxt   = (ofs == LAST_COL) ? 5'd0 : ofs + 5'd1;
        row_nxt   = '0;
        state_nxt = WRITE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and data are captured only on entry to WRITE so they stay frozen
  // for the whole CS window, even if the buffer is rewritten meanwhile.
  assign load_row = (state_nxt == WRITE) && (state != WRITE);

  always_ff @(posedge mclock) begin
    if (mreset) begin
      state      <= IDLE;
      row        <= '0;
      ofs        <= '0;
      step       <= '0;
      tmo        <= '0;
      dm_CS      <= 1'b0;
      dm_Write   <= 1'b0;
      dm_Address <= '0;
      dm_Data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      ofs        <= ofs_nxt;
      tmo        <= ((state == WRITE) && (state_nxt == WRITE)) ? tmo + 1'b1 : '0;
      if (state == FRAME_END) begin
        step <= '0;
      end else if ((state == WAIT_STEP) && tick) begin
        step <= (step == STEP_LAST) ? '0 : step + 1'b1;
      end
      dm_CS      <= (state_nxt == WRITE);
      dm_Write   <= (state_nxt == WRITE);
      if (load_row) begin
        dm_Address <= DM_ADDR_W'(row_nxt);
        dm_Data    <= row_byte;
      end
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == FRAME_END);
      if (set_err) ack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dotmatrix_scroll_ctrl.sv
// Bench for dotmatrix_scroll_ctrl: a registered-ack peripheral model plus a
// column-window reference model computed with plain modulo arithmetic.
module tb_dotmatrix_scroll_ctrl;

  localparam int MSG_COLS = 8;

  logic       mclock = 1'b0;
  logic       mreset = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       dm_CS, dm_Write, busy, frame_done, ack_err;
  logic [7:0] dm_Address, dm_Data;
  logic       dm_ack = 1'b0;
  bit         ack_en = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_msg [MSG_COLS];
  int         m_off = 0;

  int         g_rows, g_first, g_fd_in, g_fd_end, g_busy_low;
  logic       g_err_end;
  logic [7:0] g_addr [8];
  logic [7:0] g_data [8];
  int         g_len  [8];
  int         g_gap  [8];
  bit         g_stable [8];

  dotmatrix_scroll_ctrl #(
    .TICK_DIV    (4),
    .STEP_TICKS  (2),
    .MSG_COLS    (MSG_COLS),
    .ACK_TIMEOUT (15)
  ) dut (
    .mclock     (mclock),
    .mreset     (mreset),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .dm_CS      (dm_CS),
    .dm_Write   (dm_Write),
    .dm_Address (dm_Address),
    .dm_Data    (dm_Data),
    .dm_ack     (dm_ack),
    .busy       (busy),
    .frame_done (frame_done),
    .ack_err    (ack_err)
  );

  always #5 mclock = ~mclock;

  // Peripheral: registered ack one cycle after it sees CS & Write.
  always @(posedge mclock) dm_ack <= ack_en && dm_CS && dm_Write;

  function automatic logic [7:0] model_row(input int off, input int r);
    logic [7:0] b;
    for (int c = 0; c < 8; c++) b[c] = m_msg[(off + c) % MSG_COLS][r];
    return b;
  endfunction

  task automatic cfg_write(input logic [4:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge mclock);
    cfg_we = 1'b0;
    if (int'(a) < MSG_COLS) m_msg[a[2:0]] = d;
  endtask

  // Captures one 8-row frame; optionally drops enable or issues a buffer
  // write on the first CS cycle of a chosen row.
  task automatic grab_frame(input int budget, input int drop_row, input int wr_row,
                            input logic [4:0] wr_addr, input logic [7:0] wr_data);
    int cyc, cs_len, low_run;
    bit wr_pend;
    cyc = 0; cs_len = 0; low_run = 0; wr_pend = 0;
    g_rows = 0; g_first = -1; g_fd_in = 0; g_busy_low = 0;
    for (int i = 0; i < 8; i++) begin
      g_len[i] = 0; g_gap[i] = 0; g_stable[i] = 1; g_addr[i] = '0; g_data[i] = '0;
    end
    while (g_rows < 8 && cyc < budget) begin
      @(negedge mclock);
      cyc++;
      if (wr_pend) begin cfg_we = 1'b0; wr_pend = 0; end
      if (dm_CS) begin
        if (g_first < 0) g_first = cyc;
        if (cs_len == 0) begin
          g_addr[g_rows] = dm_Address;
          g_data[g_rows] = dm_Data;
          g_gap[g_rows]  = low_run;
          if (g_rows == drop_row) enable = 1'b0;
          if (g_rows == wr_row) begin
            cfg_we = 1'b1; cfg_addr = wr_addr; cfg_data = wr_data; wr_pend = 1;
          end
        end else if (dm_Address !== g_addr[g_rows] || dm_Data !== g_data[g_rows] || dm_Write !== 1'b1) begin
          g_stable[g_rows] = 0;
        end
        cs_len++;
        low_run = 0;
      end else begin
        if (cs_len > 0) begin g_len[g_rows] = cs_len; cs_len = 0; g_rows++; end
        low_run++;
        if (frame_done && g_rows < 8) g_fd_in++;
      end
      if (g_first >= 0 && !busy) g_busy_low++;
    end
    @(negedge mclock);
    if (wr_pend) cfg_we = 1'b0;
    g_fd_end  = frame_done;
    g_err_end = ack_err;
  endtask

  task automatic test_reset();
    mreset = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge mclock);
      n_cmp++;
      if ({dm_CS, dm_Write, busy, frame_done, ack_err, dm_Address, dm_Data} !== 21'd0) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d: cs=%b wr=%b busy=%b fd=%b err=%b addr=%02h data=%02h, want all 0",
                 i, dm_CS, dm_Write, busy, frame_done, ack_err, dm_Address, dm_Data);
      end
    end
    enable = 1'b0;
    @(negedge mclock);
    mreset = 1'b0;
    @(negedge mclock);
    n_cmp++;
    if (dm_CS !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: cs=%b busy=%b, want 0 0", dm_CS, busy);
    end
  endtask

  task automatic test_first_frame();
    cfg_write(5'd0, 8'hFF);
    for (int c = 1; c < MSG_COLS; c++) cfg_write(5'(c), 8'h00);
    m_off = 0;
    enable = 1'b1;
    grab_frame(100, -1, -1, 5'd0, 8'h00);
    n_cmp++;
    if (g_rows !== 8 || g_first !== 1) begin
      n_err++;
      $display("FAIL first_frame_start: rows=%0d first_cs_cycle=%0d, want 8 and 1", g_rows, g_first);
    end
    for (int r = 0; r < 8; r++) begin
      n_cmp++;
      if (g_addr[r] !== 8'(r) || g_data[r] !== model_row(m_off, r) || g_len[r] !== 2 ||
          !g_stable[r] || (r > 0 && g_gap[r] !== 1)) begin
        n_err++;
        $display("FAIL first_frame_row%0d: addr=%0d data=%02h cs=%0d gap=%0d stable=%0d, want addr=%0d data=%02h cs=2 gap=1 stable=1",
                 r, g_addr[r], g_data[r], g_len[r], g_gap[r], g_stable[r], r, model_row(m_off, r));
      end
    end
    n_cmp++;
    if (g_fd_in !== 0 || g_fd_end !== 1 || g_busy_low !== 0) begin
      n_err++;
      $display("FAIL first_frame_done: fd_inside=%0d fd_end=%0d busy_low=%0d, want 0 1 0", g_fd_in, g_fd_end, g_busy_low);
    end
  endtask

  task automatic test_step();
    for (int k = 1; k <= 8; k++) begin
      m_off = (m_off + 1) % MSG_COLS;
      grab_frame(100, -1, -1, 5'd0, 8'h00);
      n_cmp++;
      if (g_rows !== 8 || g_first !== 10 || g_fd_end !== 1) begin
        n_err++;
        $display("FAIL step%0d_timing: rows=%0d first_cs=%0d fd_end=%0d, want 8 10 1", k, g_rows, g_first, g_fd_end);
      end
      for (int r = 0; r < 8; r++) begin
        n_cmp++;
        if (g_addr[r] !== 8'(r) || g_data[r] !== model_row(m_off, r) || g_len[r] !== 2) begin
          n_err++;
          $display("FAIL step%0d_row%0d: addr=%0d data=%02h cs=%0d, want addr=%0d data=%02h cs=2",
                   k, r, g_addr[r], g_data[r], g_len[r], r, model_row(m_off, r));
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int stray;
    m_off = (m_off + 1) % MSG_COLS;
    grab_frame(100, 3, -1, 5'd0, 8'h00);
    n_cmp++;
    if (g_rows !== 8 || g_fd_end !== 1) begin
      n_err++;
      $display("FAIL drop_frame_complete: rows=%0d fd_end=%0d, want 8 1", g_rows, g_fd_end);
    end
    for (int r = 3; r < 8; r++) begin
      n_cmp++;
      if (g_addr[r] !== 8'(r) || g_data[r] !== model_row(m_off, r)) begin
        n_err++;
        $display("FAIL drop_row%0d: addr=%0d data=%02h, want addr=%0d data=%02h", r, g_addr[r], g_data[r], r, model_row(m_off, r));
      end
    end
    repeat (2) @(negedge mclock);
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      if (dm_CS || busy) stray++;
      @(negedge mclock);
    end
    n_cmp++;
    if (stray !== 0) begin
      n_err++;
      $display("FAIL drop_idle: cycles with cs/busy=%0d, want 0", stray);
    end
    enable = 1'b1;
    grab_frame(100, -1, -1, 5'd0, 8'h00);
    n_cmp++;
    if (g_rows !== 8 || g_first !== 1) begin
      n_err++;
      $display("FAIL reenable_start: rows=%0d first_cs=%0d, want 8 1", g_rows, g_first);
    end
    for (int r = 0; r < 8; r++) begin
      n_cmp++;
      if (g_data[r] !== model_row(m_off, r)) begin
        n_err++;
        $display("FAIL reenable_row%0d: data=%02h, want %02h", r, g_data[r], model_row(m_off, r));
      end
    end
  endtask

  task automatic test_random_msg();
    for (int round = 0; round < 2; round++) begin
      m_off = (m_off + 1) % MSG_COLS;
      grab_frame(100, 0, -1, 5'd0, 8'h00);
      repeat (2) @(negedge mclock);
      n_cmp++;
      if (g_rows !== 8 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rand%0d_stop: rows=%0d busy=%b, want 8 0", round, g_rows, busy);
      end
      for (int c = 0; c < MSG_COLS; c++) cfg_write(5'(c), 8'($urandom));
      cfg_write(5'(8 + $urandom_range(0, 23)), 8'($urandom));
      enable = 1'b1;
      for (int f = 0; f < 4; f++) begin
        if (f > 0) m_off = (m_off + 1) % MSG_COLS;
        grab_frame(100, -1, -1, 5'd0, 8'h00);
        for (int r = 0; r < 8; r++) begin
          n_cmp++;
          if (g_addr[r] !== 8'(r) || g_data[r] !== model_row(m_off, r)) begin
            n_err++;
            $display("FAIL rand%0d_f%0d_row%0d: addr=%0d data=%02h, want addr=%0d data=%02h (off %0d)",
                     round, f, r, g_addr[r], g_data[r], r, model_row(m_off, r), m_off);
          end
        end
      end
    end
  endtask

  task automatic test_ack_timeout();
    ack_en = 0;
    m_off = (m_off + 1) % MSG_COLS;
    grab_frame(400, -1, -1, 5'd0, 8'h00);
    n_cmp++;
    if (g_rows !== 8 || g_fd_end !== 1 || g_err_end !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_frame: rows=%0d fd_end=%0d ack_err=%b, want 8 1 1", g_rows, g_fd_end, g_err_end);
    end
    for (int r = 0; r < 8; r++) begin
      n_cmp++;
      if (g_len[r] !== 15 || g_data[r] !== model_row(m_off, r) || (r > 0 && g_gap[r] !== 1)) begin
        n_err++;
        $display("FAIL timeout_row%0d: cs=%0d gap=%0d data=%02h, want cs=15 gap=1 data=%02h",
                 r, g_len[r], g_gap[r], g_data[r], model_row(m_off, r));
      end
    end
    ack_en = 1;
    m_off = (m_off + 1) % MSG_COLS;
    grab_frame(100, -1, -1, 5'd0, 8'h00);
    n_cmp++;
    if (g_rows !== 8 || g_len[0] !== 2 || g_len[7] !== 2 || g_err_end !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: rows=%0d cs0=%0d cs7=%0d ack_err=%b, want 8 2 2 1", g_rows, g_len[0], g_len[7], g_err_end);
    end
  endtask

  task automatic test_reset_midframe();
    int cyc;
    cyc = 0;
    while (!(dm_CS && dm_Address == 8'd4) && cyc < 200) begin
      @(negedge mclock);
      cyc++;
    end
    n_cmp++;
    if (cyc >= 200) begin
      n_err++;
      $display("FAIL midreset_wait: row 4 not seen within %0d cycles", cyc);
    end
    mreset = 1'b1; enable = 1'b0;
    @(negedge mclock);
    n_cmp++;
    if ({dm_CS, dm_Write, busy, frame_done, ack_err, dm_Address, dm_Data} !== 21'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: cs=%b wr=%b busy=%b fd=%b err=%b addr=%02h data=%02h, want all 0",
               dm_CS, dm_Write, busy, frame_done, ack_err, dm_Address, dm_Data);
    end
    mreset = 1'b0;
    m_off = 0;
    repeat (3) @(negedge mclock);
    n_cmp++;
    if (dm_CS !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_idle: cs=%b busy=%b, want 0 0", dm_CS, busy);
    end
  endtask

  task automatic test_cfg_writes();
    logic [7:0] exp_old [8];
    logic [7:0] exp_new [8];
    cfg_write(5'd0, 8'hFF);
    for (int c = 1; c < MSG_COLS; c++) cfg_write(5'(c), 8'h00);
    cfg_write(5'd9, 8'hFF);
    cfg_write(5'd31, 8'hAA);
    for (int r = 0; r < 8; r++) exp_old[r] = model_row(m_off, r);
    m_msg[1] = 8'hFF;
    for (int r = 0; r < 8; r++) exp_new[r] = model_row(m_off, r);
    enable = 1'b1;
    grab_frame(100, -1, 5, 5'd1, 8'hFF);
    n_cmp++;
    if (g_rows !== 8 || g_first !== 1) begin
      n_err++;
      $display("FAIL cfg_frame_start: rows=%0d first_cs=%0d, want 8 1", g_rows, g_first);
    end
    for (int r = 0; r < 8; r++) begin
      n_cmp++;
      if (g_data[r] !== ((r <= 5) ? exp_old[r] : exp_new[r])) begin
        n_err++;
        $display("FAIL cfg_row%0d: data=%02h, want %02h", r, g_data[r], (r <= 5) ? exp_old[r] : exp_new[r]);
      end
    end
    enable = 1'b0;
    repeat (20) @(negedge mclock);
  endtask

  initial begin
    for (int c = 0; c < MSG_COLS; c++) m_msg[c] = 8'h00;
    test_reset();
    test_first_frame();
    test_step();
    test_enable_drop();
    test_random_msg();
    test_ack_timeout();
    test_reset_midframe();
    test_cfg_writes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
